// File: rtl/div_iter_unit.sv
// -----------------------------------------------------------------------------
// div_iter_unit
//   Multi-cycle radix-2 restoring divider for the EX stage. Handles signed and
//   unsigned operands and computes one quotient bit per cycle. The result is
//   packed as {remainder, quotient}.
//
//   Optional build macro: DIV_EARLY_TERM_EN
//     When defined, PREP counts the leading zeros of |dividend| and skips those
//     iterations. The results are bit-identical to the default build; only the
//     latency changes.
//
// Ports
//   clk         clock
//   rst         asynchronous active-high reset
//   start_i     request a division (sampled only while idle)
//   annul_i     abort the current operation (flush)
//   signed_i    1 = signed divide, 0 = unsigned (latched with start_i)
//   opdata1_i   dividend (latched with start_i)
//   opdata2_i   divisor  (latched with start_i)
//   result_o    {remainder, quotient}; holds until the next completion
//   ready_o     one-cycle pulse: result_o is valid
//   busy_o      high whenever the unit is not idle
//   div_zero_o  divisor was zero (qualified by ready_o)
// -----------------------------------------------------------------------------
module div_iter_unit #(
   parameter int WIDTH = 32,
   parameter int CNT_W = $clog2(WIDTH+1)
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               start_i,
   input  logic               annul_i,
   input  logic               signed_i,
   input  logic [WIDTH-1:0]   opdata1_i,
   input  logic [WIDTH-1:0]   opdata2_i,
   output logic [2*WIDTH-1:0] result_o,
   output logic               ready_o,
   output logic               busy_o,
   output logic               div_zero_o
);

   localparam logic [1:0] S_IDLE = 2'd0;
   localparam logic [1:0] S_PREP = 2'd1;
   localparam logic [1:0] S_CALC = 2'd2;
   localparam logic [1:0] S_DONE = 2'd3;

   localparam logic [CNT_W-1:0] W_CNT = CNT_W'(WIDTH);

   logic [1:0]         state_q,   state_d;
   logic [CNT_W-1:0]   cnt_q,     cnt_d;
   logic [WIDTH-1:0]   rem_q,     rem_d;      // partial remainder
   logic [WIDTH-1:0]   quo_q,     quo_d;      // dividend shifts out, quotient shifts in
   logic [WIDTH-1:0]   dvs_q,     dvs_d;      // divisor magnitude
   logic [WIDTH-1:0]   op1_q,     op1_d;
   logic [WIDTH-1:0]   op2_q,     op2_d;
   logic               sgn_q,     sgn_d;
   logic               neg_quo_q, neg_quo_d;
   logic               neg_rem_q, neg_rem_d;
   logic [2*WIDTH-1:0] result_q,  result_d;
   logic               ready_q,   ready_d;
   logic               busy_q,    busy_d;
   logic               dz_q,      dz_d;

   // Operand magnitudes. The negate of the most negative value wraps to itself,
   // which is exactly what the unsigned datapath needs for the overflow case.
   logic [WIDTH-1:0] abs1, abs2;
   assign abs1 = (sgn_q && op1_q[WIDTH-1]) ? (~op1_q + 1'b1) : op1_q;
   assign abs2 = (sgn_q && op2_q[WIDTH-1]) ? (~op2_q + 1'b1) : op2_q;

   // One restoring step. The partial remainder is always smaller than the
   // divisor, so the shifted value fits in WIDTH+1 bits. The sign bit of the
   // difference tells whether the subtraction is kept.
   logic [WIDTH:0]   trial_w, diff_w;
   logic [WIDTH-1:0] rem_nx, quo_nx, rem_fix, quo_fix;
   assign trial_w = {rem_q, quo_q[WIDTH-1]};
   assign diff_w  = trial_w - {1'b0, dvs_q};
   assign rem_nx  = diff_w[WIDTH] ? trial_w[WIDTH-1:0] : diff_w[WIDTH-1:0];
   assign quo_nx  = {quo_q[WIDTH-2:0], ~diff_w[WIDTH]};
   assign quo_fix = neg_quo_q ? (~quo_nx + 1'b1) : quo_nx;
   assign rem_fix = neg_rem_q ? (~rem_nx + 1'b1) : rem_nx;

`ifdef DIV_EARLY_TERM_EN
   // Leading-zero count of |dividend|. The highest set bit wins because it is
   // visited last.
   logic [CNT_W-1:0] lz;
   always_comb begin
      lz = W_CNT;
      for (int i = 0; i < WIDTH; i++) begin
         if (abs1[i]) begin
            lz = CNT_W'(WIDTH - 1 - i);
         end
      end
   end
`endif

   always_comb begin
      state_d   = state_q;
      cnt_d     = cnt_q;
      rem_d     = rem_q;
      quo_d     = quo_q;
      dvs_d     = dvs_q;
      op1_d     = op1_q;
      op2_d     = op2_q;
      sgn_d     = sgn_q;
      neg_quo_d = neg_quo_q;
      neg_rem_d = neg_rem_q;
      result_d  = result_q;
      dz_d      = 1'b0;

      case (state_q)
         S_IDLE: begin
            if (start_i && !annul_i) begin
               op1_d   = opdata1_i;
               op2_d   = opdata2_i;
               sgn_d   = signed_i;
               state_d = S_PREP;
            end
         end

         S_PREP: begin
            if (annul_i) begin
               state_d = S_IDLE;
            end else if (op2_q == '0) begin
               result_d = {op1_q, {WIDTH{1'b1}}};
               dz_d     = 1'b1;
               state_d  = S_DONE;
            end else begin
               dvs_d     = abs2;
               neg_quo_d = sgn_q & (op1_q[WIDTH-1] ^ op2_q[WIDTH-1]);
               neg_rem_d = sgn_q & op1_q[WIDTH-1];
               rem_d     = '0;
`ifdef DIV_EARLY_TERM_EN
               if (abs1 == '0) begin
                  quo_d    = '0;
                  cnt_d    = '0;
                  result_d = '0;
                  state_d  = S_DONE;
               end else begin
                  quo_d   = abs1 << lz;
                  cnt_d   = W_CNT - lz;
                  state_d = S_CALC;
               end
`else
               quo_d   = abs1;
               cnt_d   = W_CNT;
               state_d = S_CALC;
`endif
            end
         end

         S_CALC: begin
            if (annul_i) begin
               state_d = S_IDLE;
            end else begin
               rem_d = rem_nx;
               quo_d = quo_nx;
               cnt_d = cnt_q - CNT_W'(1);
               if (cnt_q == CNT_W'(1)) begin
                  // The result register is loaded on entry to DONE so that
                  // result_o and ready_o become visible in the same cycle.
                  result_d = {rem_fix, quo_fix};
                  state_d  = S_DONE;
               end
            end
         end

         S_DONE: begin
            state_d = S_IDLE;
         end

         default: begin
            state_d = S_IDLE;
         end
      endcase

      // Outputs are registered from the next state, so ready/busy follow the
      // state exactly without any combinational input-to-output path.
      ready_d = (state_d == S_DONE);
      busy_d  = (state_d != S_IDLE);
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q   <= S_IDLE;
         cnt_q     <= '0;
         rem_q     <= '0;
         quo_q     <= '0;
         dvs_q     <= '0;
         op1_q     <= '0;
         op2_q     <= '0;
         sgn_q     <= 1'b0;
         neg_quo_q <= 1'b0;
         neg_rem_q <= 1'b0;
         result_q  <= '0;
         ready_q   <= 1'b0;
         busy_q    <= 1'b0;
         dz_q      <= 1'b0;
      end else begin
         state_q   <= state_d;
         cnt_q     <= cnt_d;
         rem_q     <= rem_d;
         quo_q     <= quo_d;
         dvs_q     <= dvs_d;
         op1_q     <= op1_d;
         op2_q     <= op2_d;
         sgn_q     <= sgn_d;
         neg_quo_q <= neg_quo_d;
         neg_rem_q <= neg_rem_d;
         result_q  <= result_d;
         ready_q   <= ready_d;
         busy_q    <= busy_d;
         dz_q      <= dz_d;
      end
   end

   assign result_o   = result_q;
   assign ready_o    = ready_q;
   assign busy_o     = busy_q;
   assign div_zero_o = dz_q;

endmodule

// File: tb/tb_div_iter_unit.sv
// -----------------------------------------------------------------------------
// tb_div_iter_unit
//   Scoreboard bench for div_iter_unit (WIDTH=32). The driver pushes the
//   expected {result, div_zero, completion cycle} for each accepted division;
//   the monitor pops and compares on every ready_o pulse.
//   Honours DIV_EARLY_TERM_EN for the expected latency.
// -----------------------------------------------------------------------------
module tb_div_iter_unit;

   localparam int W = 32;

   logic          clk = 1'b0;
   logic          rst = 1'b1;
   logic          start_i = 1'b0;
   logic          annul_i = 1'b0;
   logic          signed_i = 1'b0;
   logic [W-1:0]  opdata1_i = '0;
   logic [W-1:0]  opdata2_i = '0;
   logic [2*W-1:0] result_o;
   logic          ready_o;
   logic          busy_o;
   logic          div_zero_o;

   div_iter_unit #(.WIDTH(W)) dut (
      .clk        (clk),
      .rst        (rst),
      .start_i    (start_i),
      .annul_i    (annul_i),
      .signed_i   (signed_i),
      .opdata1_i  (opdata1_i),
      .opdata2_i  (opdata2_i),
      .result_o   (result_o),
      .ready_o    (ready_o),
      .busy_o     (busy_o),
      .div_zero_o (div_zero_o)
   );

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   typedef struct {
      logic [2*W-1:0] res;
      logic           dz;
      int             at_cyc;
   } exp_t;

   exp_t           sb[$];
   int             checks = 0;
   int             errors = 0;
   logic [2*W-1:0] last_res = '0;

   task automatic chk(input string name, input logic [2*W-1:0] act, input logic [2*W-1:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   // Reference model: plain arithmetic on the operands.
   function automatic void model(input logic s, input logic [W-1:0] a, input logic [W-1:0] b,
                                 output logic [2*W-1:0] res, output logic dz, output int lat);
      logic [W-1:0] q, r, mag;
      int sa, sbv, bits;
      dz = 1'b0;
      if (b == 0) begin
         q = '1; r = a; dz = 1'b1;
      end else if (s) begin
         if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
            q = a; r = '0;
         end else begin
            sa = a; sbv = b;
            q = W'(sa / sbv);
            r = W'(sa % sbv);
         end
      end else begin
         q = a / b;
         r = a % b;
      end
      res = {r, q};
      if (b == 0) begin
         lat = 2;
      end else begin
`ifdef DIV_EARLY_TERM_EN
         mag = (s && a[W-1]) ? -a : a;
         bits = 0;
         while (mag != 0) begin bits++; mag = mag >> 1; end
         lat = bits + 2;
`else
         mag = a;
         bits = W;
         lat = bits + 2;
`endif
      end
   endfunction

   // Monitor: every ready pulse must match the oldest expectation.
   always @(negedge clk) begin
      exp_t e;
      if (!rst && ready_o) begin
         if (sb.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_ready: got result %h with no pending operation", result_o);
         end else begin
            e = sb.pop_front();
            chk("result", result_o, e.res);
            chk("div_zero", 64'(div_zero_o), 64'(e.dz));
            chk("latency_cycle", 64'(cyc), 64'(e.at_cyc));
            $display("txn result=%h dz=%0d cyc=%0d", result_o, div_zero_o, cyc);
            last_res = e.res;
         end
      end
   end

   // Issue one start; optionally register its expectation.
   task automatic issue(input logic s, input logic [W-1:0] a, input logic [W-1:0] b,
                        input bit push, output int lat);
      exp_t e;
      logic [2*W-1:0] res;
      logic dz;
      model(s, a, b, res, dz, lat);
      @(negedge clk);
      start_i = 1'b1; signed_i = s; opdata1_i = a; opdata2_i = b; annul_i = 1'b0;
      @(posedge clk);
      #1;
      start_i = 1'b0;
      opdata1_i = $urandom; opdata2_i = $urandom; signed_i = $urandom_range(0, 1);
      chk("busy_after_start", 64'(busy_o), 64'(1));
      if (push) begin
         e.res = res; e.dz = dz; e.at_cyc = cyc + lat - 1;
         sb.push_back(e);
      end
   endtask

   task automatic wait_done();
      for (int i = 0; i < 200 && sb.size() != 0; i++) begin
         @(negedge clk);
         #1;
      end
      if (sb.size() != 0) begin
         checks++;
         errors++;
         $display("FAIL timeout: %0d results still pending, required 0", sb.size());
         sb.delete();
      end
      @(negedge clk);
      #1;
      chk("busy_idle", 64'(busy_o), 64'(0));
      chk("result_hold", result_o, last_res);
   endtask

   task automatic run_one(input logic s, input logic [W-1:0] a, input logic [W-1:0] b);
      int lat;
      issue(s, a, b, 1'b1, lat);
      wait_done();
   endtask

   initial begin
      int lat;
      logic s;
      logic [W-1:0] a, b;

      repeat (3) @(posedge clk);
      @(negedge clk);
      chk("reset_result", result_o, '0);
      chk("reset_ready", 64'(ready_o), 64'(0));
      chk("reset_busy", 64'(busy_o), 64'(0));
      chk("reset_dz", 64'(div_zero_o), 64'(0));
      rst = 1'b0;

      // Directed vectors
      run_one(1'b0, 32'd100, 32'd7);
      run_one(1'b1, 32'hFFFF_FFF9, 32'h0000_0002);
      run_one(1'b1, 32'h0000_0007, 32'hFFFF_FFFE);
      run_one(1'b0, 32'h1234_5678, 32'h0000_0000);
      run_one(1'b1, 32'h8000_0000, 32'hFFFF_FFFF);
      run_one(1'b0, 32'hFFFF_FFFF, 32'h0000_0001);

      // start together with annul is ignored
      @(negedge clk);
      start_i = 1'b1; annul_i = 1'b1; opdata1_i = 32'd50; opdata2_i = 32'd5;
      @(posedge clk); #1;
      start_i = 1'b0; annul_i = 1'b0;
      chk("start_with_annul_ignored", 64'(busy_o), 64'(0));

      // Annul mid-CALC: no ready, busy drops, result held; then a fresh start.
      issue(1'b0, 32'd100, 32'd7, 1'b0, lat);
      repeat (9) @(negedge clk);
      annul_i = 1'b1;
      @(posedge clk); #1;
      annul_i = 1'b0;
      chk("annul_busy_low", 64'(busy_o), 64'(0));
      chk("annul_result_held", result_o, last_res);
      run_one(1'b0, 32'd9, 32'd3);

      // Random operations, with a stray start and operand changes mid-flight.
      for (int n = 0; n < 40; n++) begin
         s = $urandom_range(0, 1);
         case ($urandom_range(0, 3))
            0: a = $urandom_range(0, 255);
            1: a = 32'h8000_0000;
            default: a = $urandom;
         endcase
         case ($urandom_range(0, 7))
            0: b = '0;
            1: b = 32'd1;
            2: b = 32'hFFFF_FFFF;
            3: b = $urandom_range(1, 15);
            default: b = $urandom;
         endcase
         issue(s, a, b, 1'b1, lat);
         if (lat >= 6) begin
            @(negedge clk);
            start_i = 1'b1; opdata1_i = $urandom; opdata2_i = $urandom;
            @(negedge clk);
            start_i = 1'b0;
         end
         wait_done();
      end

      // Asynchronous reset in the middle of CALC.
      issue(1'b0, 32'd100, 32'd7, 1'b0, lat);
      repeat (10) @(negedge clk);
      #2 rst = 1'b1;
      #1;
      chk("async_rst_result", result_o, '0);
      chk("async_rst_ready", 64'(ready_o), 64'(0));
      chk("async_rst_busy", 64'(busy_o), 64'(0));
      chk("async_rst_dz", 64'(div_zero_o), 64'(0));
      last_res = '0;
      @(negedge clk);
      rst = 1'b0;
      repeat (40) @(negedge clk);
      chk("no_ready_after_rst", result_o, '0);
      run_one(1'b0, 32'd9, 32'd3);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation did not finish, required completion");
      $fatal(1, "watchdog");
   end

endmodule
